// File: rtl/mem_pattern_tester.sv
// Pattern write / pipelined read-back tester for the SDRAM controller request port.
// Optional watchdog enabled by defining MEMTEST_TIMEOUT_EN.
module mem_pattern_tester #(
  parameter int          AW      = 22,
  parameter int          DW      = 16,
  parameter int          NWORDS  = 256,
  parameter int          MAX_OUT = 4,
  parameter int          CW      = 8,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] base_addr,
  input  logic          mem_busy,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_oe,
  output logic [DW-1:0] read_value,
  output logic [AW-1:0] first_err_addr,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] tested_count,
  output logic          busy,
  output logic          finish,
  output logic          timeout
);

  localparam int IW = (AW + 1 > DW) ? AW + 1 : DW;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);
  localparam logic [IW-1:0] NW   = IW'(NWORDS);
  localparam logic [OW-1:0] MAXO = OW'(MAX_OUT);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t        state, state_nx;
  logic          start_q, launch;
  logic [1:0]    mode_q;
  logic [AW-1:0] base_q;
  logic [IW-1:0] w_idx, r_idx;
  logic [DW-1:0] w_walk, r_walk;
  logic [15:0]   w_lfsr, r_lfsr;
  logic [OW-1:0] outst;
  logic          err_seen;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_pat, r_pat;
  logic          wr_acc, rd_acc, vld, wr_last, rd_last, wd_fire;

  // Fibonacci LFSR, taps 16,14,13,11, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [DW-1:0] rotl1(input logic [DW-1:0] v);
    return {v[DW-2:0], v[DW-1]};
  endfunction

  function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [IW-1:0] i,
                                            input logic [DW-1:0] walk, input logic [15:0] l);
    logic [DW+15:0] lx;
    lx = {{DW{1'b0}}, l};
    case (m)
      2'd0:    return i[DW-1:0];
      2'd1:    return ~i[DW-1:0];
      2'd2:    return walk;
      default: return lx[DW-1:0];
    endcase
  endfunction

  assign launch  = start & ~start_q & ((state == IDLE) | (state == DONE));
  assign wr_acc  = mem_we & ~mem_busy;
  assign rd_acc  = mem_oe & ~mem_busy;
  assign vld     = mem_valid & (state == READ) & (outst != '0);
  assign wr_last = wr_acc & (w_idx == LAST);
  assign rd_last = vld & (r_idx == LAST);
  assign w_addr  = base_q + w_idx[AW-1:0];
  assign w_pat   = pattern(mode_q, w_idx, w_walk, w_lfsr);
  assign r_pat   = pattern(mode_q, r_idx, r_walk, r_lfsr);

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (launch) state_nx = WRITE;
      WRITE: begin
        if (wd_fire)      state_nx = DONE;
        else if (wr_last) state_nx = READ;
      end
      READ: begin
        if (wd_fire || rd_last) state_nx = DONE;
      end
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = w_addr;
        mem_wdata = w_pat;
        busy      = 1'b1;
      end
      READ: begin
        mem_oe   = (w_idx < NW) && (outst < MAXO);
        mem_addr = w_addr;
        busy     = 1'b1;
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q        <= 1'b0;
      mode_q         <= '0;
      base_q         <= '0;
      w_idx          <= '0;
      w_walk         <= DW'(1);
      w_lfsr         <= SEED;
      r_idx          <= '0;
      r_walk         <= DW'(1);
      r_lfsr         <= SEED;
      outst          <= '0;
      read_value     <= '0;
      first_err_addr <= '0;
      err_count      <= '0;
      tested_count   <= '0;
      err_seen       <= 1'b0;
    end else begin
      start_q <= start;
      if (launch) begin
        mode_q         <= mode;
        base_q         <= base_addr;
        w_idx          <= '0;
        w_walk         <= DW'(1);
        w_lfsr         <= SEED;
        r_idx          <= '0;
        r_walk         <= DW'(1);
        r_lfsr         <= SEED;
        outst          <= '0;
        read_value     <= '0;
        first_err_addr <= '0;
        err_count      <= '0;
        tested_count   <= '0;
        err_seen       <= 1'b0;
      end else begin
        // The issue side restarts from index 0 to walk the window again for reads.
        if (wr_last) begin
          w_idx  <= '0;
          w_walk <= DW'(1);
          w_lfsr <= SEED;
        end else if (wr_acc || rd_acc) begin
          w_idx  <= w_idx + IW'(1);
          w_walk <= rotl1(w_walk);
          w_lfsr <= lfsr_next(w_lfsr);
        end

        case ({rd_acc, vld})
          2'b10:   outst <= outst + OW'(1);
          2'b01:   outst <= outst - OW'(1);
          default: ;
        endcase

        if (vld) begin
          read_value <= mem_rdata;
          r_idx      <= r_idx + IW'(1);
          r_walk     <= rotl1(r_walk);
          r_lfsr     <= lfsr_next(r_lfsr);
          if (tested_count != CMAX) tested_count <= tested_count + CW'(1);
          if (mem_rdata != r_pat) begin
            if (err_count != CMAX) err_count <= err_count + CW'(1);
            if (!err_seen) begin
              first_err_addr <= base_q + r_idx[AW-1:0];
              err_seen       <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef MEMTEST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt;
  logic          timeout_q;

  // Fires on the idle cycle that would take the count to TIMEOUT.
  assign wd_fire = busy & ~wr_acc & ~rd_acc & ~mem_valid & (wd_cnt == TW'(TIMEOUT - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (launch || !busy || wr_acc || rd_acc || mem_valid) wd_cnt <= '0;
      else                                                   wd_cnt <= wd_cnt + TW'(1);
      if (launch)       timeout_q <= 1'b0;
      else if (wd_fire) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_fire        = 1'b0;
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Scoreboard bench for mem_pattern_tester: a behavioural SDRAM model checks every request
// against queued expectations; a second instance exercises counter saturation in LFSR mode.
`timescale 1ns/1ps
module tb_mem_pattern_tester;

  localparam int AW = 22, DW = 16, NW = 16, MAXO = 4, TO = 32, NWS = 20;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic          start = 0, mem_busy = 0, mem_valid = 0;
  logic [1:0]    mode = 0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr, first_err_addr;
  logic [DW-1:0] mem_wdata, read_value;
  logic          mem_we, mem_oe, busy, finish, timeout;
  logic [7:0]    err_count, tested_count;

  logic          start_s = 0, mem_busy_s = 0, mem_valid_s = 0;
  logic [1:0]    mode_s = 2'd3;
  logic [AW-1:0] base_s = 22'h000100;
  logic [DW-1:0] mem_rdata_s = '0;
  logic [AW-1:0] mem_addr_s, first_err_addr_s;
  logic [DW-1:0] mem_wdata_s, read_value_s;
  logic          mem_we_s, mem_oe_s, busy_s, finish_s, timeout_s;
  logic [3:0]    err_count_s, tested_count_s;

  mem_pattern_tester #(.AW(AW), .DW(DW), .NWORDS(NW), .MAX_OUT(MAXO), .CW(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .mem_busy(mem_busy), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
    .read_value(read_value), .first_err_addr(first_err_addr), .err_count(err_count),
    .tested_count(tested_count), .busy(busy), .finish(finish), .timeout(timeout));

  mem_pattern_tester #(.AW(AW), .DW(DW), .NWORDS(NWS), .MAX_OUT(MAXO), .CW(4), .TIMEOUT(TO)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .mode(mode_s), .base_addr(base_s),
    .mem_busy(mem_busy_s), .mem_valid(mem_valid_s), .mem_rdata(mem_rdata_s),
    .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_we(mem_we_s), .mem_oe(mem_oe_s),
    .read_value(read_value_s), .first_err_addr(first_err_addr_s), .err_count(err_count_s),
    .tested_count(tested_count_s), .busy(busy_s), .finish(finish_s), .timeout(timeout_s));

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pat(input logic [1:0] m, input int i);
    logic [15:0] l, iv;
    l  = 16'hACE1;
    iv = i[15:0];
    for (int k = 0; k < i; k++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    case (m)
      2'd0:    return iv;
      2'd1:    return ~iv;
      2'd2:    return 16'h0001 << (i % 16);
      default: return l;
    endcase
  endfunction

  // ---------------- memory model for the main instance ----------------
  wr_t           exp_wr[$], exp_wr_s[$];
  logic [AW-1:0] exp_rd[$];
  rd_t           pend[$], pend_s[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            cyc = 0, lat = 2, b_out = 0, peak = 0, last_rd_cyc = 0;
  bit            busy_toggle = 0, no_valid = 0, corrupt_en = 0, held = 0;
  logic [AW-1:0] corrupt_addr = '0, held_addr = '0;
  logic [DW-1:0] held_data = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    mem_busy  = busy_toggle && (cyc % 2 == 1);
    mem_valid = 0;
    mem_rdata = '0;
    if (!no_valid && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_valid = 1;
      mem_rdata = pend[0].data;
      void'(pend.pop_front());
      b_out--;
    end
    if (rst_n) begin
      if (mem_we && mem_oe) check("we_oe_exclusive", 1, 0);
      if (held) begin
        check("hold_we", mem_we, 1);
        check("hold_addr", mem_addr, held_addr);
        check("hold_data", mem_wdata, held_data);
      end
      held      = mem_we && mem_busy;
      held_addr = mem_addr;
      held_data = mem_wdata;
      if (mem_we && !mem_busy) begin
        wr_t e;
        if (exp_wr.size() == 0) check("write_extra", 1, 0);
        else begin
          e = exp_wr.pop_front();
          check("write_addr", mem_addr, e.addr);
          check("write_data", mem_wdata, e.data);
        end
        mem[mem_addr] = mem_wdata;
      end
      if (mem_oe && !mem_busy) begin
        logic [DW-1:0] d;
        if (exp_rd.size() == 0) check("read_extra", 1, 0);
        else check("read_addr", mem_addr, exp_rd.pop_front());
        d = mem.exists(mem_addr) ? mem[mem_addr] : '0;
        if (corrupt_en && mem_addr == corrupt_addr) d = '0;
        pend.push_back('{cyc + lat, d});
        b_out++;
        if (b_out > peak) peak = b_out;
        last_rd_cyc = cyc;
      end
    end else held = 0;
  end

  // ---------------- memory model for the saturation instance ----------------
  int cyc_s = 0, rd_idx_s = 0;

  initial forever begin
    @(negedge clk);
    cyc_s++;
    mem_valid_s = 0;
    mem_rdata_s = '0;
    if (pend_s.size() > 0 && pend_s[0].due <= cyc_s) begin
      mem_valid_s = 1;
      mem_rdata_s = pend_s[0].data;
      void'(pend_s.pop_front());
    end
    if (rst_n && mem_we_s) begin
      wr_t e;
      if (exp_wr_s.size() == 0) check("sat_write_extra", 1, 0);
      else begin
        e = exp_wr_s.pop_front();
        check("sat_write_addr", mem_addr_s, e.addr);
        check("sat_write_data", mem_wdata_s, e.data);
      end
    end
    if (rst_n && mem_oe_s) begin
      check("sat_read_addr", mem_addr_s, base_s + AW'(rd_idx_s));
      rd_idx_s++;
      pend_s.push_back('{cyc_s + 1, 16'hFFFF});
    end
  end

  // ---------------- stimulus ----------------
  task automatic launch(input logic [1:0] m, input logic [AW-1:0] b);
    wr_t e;
    peak = 0;
    for (int i = 0; i < NW; i++) begin
      e.addr = b + AW'(i);
      e.data = exp_pat(m, i);
      exp_wr.push_back(e);
      exp_rd.push_back(e.addr);
    end
    mode = m;
    base_addr = b;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    check("launch_busy", busy, 1);
    check("launch_finish", finish, 0);
  endtask

  task automatic wait_finish();
    int n;
    n = 0;
    while (!finish && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("pass_finished", finish, 1);
    check("pass_busy_clear", busy, 0);
  endtask

  task automatic run_pass(input logic [1:0] m, input logic [AW-1:0] b, input bit mid);
    launch(m, b);
    if (mid) begin
      for (int k = 0; k < 3; k++) begin
        repeat (12) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1;
        start = 0;
      end
    end
    wait_finish();
    check("writes_left", exp_wr.size(), 0);
    check("reads_left", exp_rd.size(), 0);
  endtask

  initial begin
    int n, reqs, exp_errs, first_idx;
    wr_t e;

    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", mem_we, 0);
    check("rst_oe", mem_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_timeout", timeout, 0);
    check("rst_counts", {err_count, tested_count}, 0);
    check("rst_regs", {read_value, first_err_addr, mem_addr, mem_wdata}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // mode0, ideal memory
    lat = 2;
    run_pass(2'd0, '0, 0);
    check("m0_err", err_count, 0);
    check("m0_tested", tested_count, 16);
    check("m0_first_err", first_err_addr, 0);
    check("m0_read_value", read_value, 16'h000F);
    check("m0_peak_le_max", peak <= MAXO, 1);

    // mode2, address 5 corrupted, long latency to fill the pipeline
    lat = 8;
    corrupt_en = 1;
    corrupt_addr = 22'd5;
    run_pass(2'd2, '0, 0);
    corrupt_en = 0;
    check("m2_err", err_count, 1);
    check("m2_first_err", first_err_addr, 22'd5);
    check("m2_tested", tested_count, 16);
    check("m2_read_value", read_value, 16'h8000);
    check("m2_peak_eq_max", peak, MAXO);

    // mode1 across the address wrap, busy toggling, start pulses mid-pass
    lat = 2;
    busy_toggle = 1;
    run_pass(2'd1, 22'h3FFFFE, 1);
    busy_toggle = 0;
    check("m1_err", err_count, 0);
    check("m1_tested", tested_count, 16);
    check("m1_first_err_cleared", first_err_addr, 0);
    check("m1_read_value", read_value, 16'hFFF0);

    // reset during READ with 3 outstanding
    lat = 6;
    launch(2'd0, '0);
    n = 0;
    while (b_out != 3 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reached_3_outstanding", b_out, 3);
    rst_n = 0;
    #1;
    check("mid_rst_outputs", {mem_we, mem_oe, busy, finish, timeout, |mem_addr, |mem_wdata,
                              |read_value, |first_err_addr, |err_count, |tested_count}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    exp_wr.delete();
    exp_rd.delete();
    reqs = 0;
    repeat (12) begin
      @(posedge clk); #1;
      reqs += int'(mem_we | mem_oe);
    end
    check("mid_no_request", reqs, 0);
    check("mid_valids_ignored", tested_count, 0);
    check("mid_read_value", read_value, 0);
    check("mid_idle", {busy, finish}, 0);
    check("mid_pending_drained", pend.size(), 0);
    b_out = 0;

    // watchdog
    lat = 2;
    no_valid = 1;
    launch(2'd0, '0);
`ifdef MEMTEST_TIMEOUT_EN
    n = 0;
    while (!finish && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_finish", finish, 1);
    check("to_flag", timeout, 1);
    check("to_latency", cyc - last_rd_cyc, TO);
    check("to_reads_issued", NW - exp_rd.size(), MAXO);
    check("to_tested", tested_count, 0);
`else
    repeat (100) @(posedge clk);
    #1;
    check("nowd_busy", busy, 1);
    check("nowd_timeout", timeout, 0);
    check("nowd_finish", finish, 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
`endif
    pend.delete();
    b_out = 0;
    no_valid = 0;
    exp_wr.delete();
    exp_rd.delete();
    run_pass(2'd0, '0, 0);
    check("relaunch_timeout_clear", timeout, 0);
    check("relaunch_tested", tested_count, 16);
    check("relaunch_err", err_count, 0);

    // mode3 LFSR on the CW=4 instance against an all-ones memory
    exp_errs = 0;
    first_idx = -1;
    for (int i = 0; i < NWS; i++) begin
      e.addr = base_s + AW'(i);
      e.data = exp_pat(2'd3, i);
      exp_wr_s.push_back(e);
      if (e.data != 16'hFFFF) begin
        exp_errs++;
        if (first_idx < 0) first_idx = i;
      end
    end
    start_s = 1;
    @(posedge clk); #1;
    start_s = 0;
    check("sat_launch_busy", busy_s, 1);
    for (int k = 0; k < 3; k++) begin
      repeat (8) @(posedge clk);
      #1 start_s = 1;
      @(posedge clk); #1;
      start_s = 0;
    end
    n = 0;
    while (!finish_s && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("sat_finished", finish_s, 1);
    check("sat_err", err_count_s, (exp_errs > 15) ? 15 : exp_errs);
    check("sat_tested", tested_count_s, 15);
    check("sat_first_err", first_err_addr_s, base_s + AW'(first_idx));
    check("sat_read_value", read_value_s, 16'hFFFF);
    check("sat_writes_left", exp_wr_s.size(), 0);
    check("sat_reads_issued", rd_idx_s, NWS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stalled expected finished");
    $fatal(1, "bench stalled");
  end

endmodule
